// File: rtl/bin_clock_pkg.sv
// Shared types and limits for the binary-clock timekeeper.
// Field widths, wrap limits and the mode encoding.
package bin_clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } mode_t;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
  localparam logic [HR_W-1:0]  H12_MAX = 5'd12;

endpackage

// File: rtl/bin_clock_timekeeper_if.sv
// Button inputs and time/mode outputs of the timekeeper.
// master drives the buttons, slave is the timekeeper itself.
interface bin_clock_timekeeper_if;
  import bin_clock_pkg::*;

  logic             btn_set;
  logic             btn_inc;
  logic [SEC_W-1:0] sec;
  logic [MIN_W-1:0] min;
  logic [HR_W-1:0]  hr;
  logic             pm;
  logic [1:0]       mode;
  logic             sec_pulse;

  modport master (
    output btn_set, btn_inc,
    input  sec, min, hr, pm, mode, sec_pulse
  );

  modport slave (
    input  btn_set, btn_inc,
    output sec, min, hr, pm, mode, sec_pulse
  );

endinterface

// File: rtl/bin_clock_btn_sync.sv
// Button synchroniser chain with a one-clock rising-edge strobe.
// Holding the button high yields a single strobe.
module bin_clock_btn_sync #(
  parameter int SYNC_FF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  logic [SYNC_FF-1:0] sync_q;
  logic               prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_FF-2:0], btn_i};
      prev_q <= sync_q[SYNC_FF-1];
    end
  end

  assign rise_o = sync_q[SYNC_FF-1] & ~prev_q;

endmodule

// File: rtl/bin_clock_timekeeper.sv
// Time-of-day core: 1 Hz prescaler, set/adjust FSM, h:m:s counters.
// Define BIN_CLOCK_H12_EN for a 12 h display with PM flag.
module bin_clock_timekeeper
  import bin_clock_pkg::*;
#(
  parameter int CLK_HZ  = 10_000_000,
  parameter int SYNC_FF = 2
) (
  input  logic clk,
  input  logic rst,
  bin_clock_timekeeper_if.slave bus
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

`ifdef BIN_CLOCK_H12_EN
  localparam logic [HR_W-1:0] HR_RST = H12_MAX;

  // 12,1..11; PM flips when 11 rolls over to 12
  function automatic logic [HR_W:0] hr_step(
    input logic pm, input logic [HR_W-1:0] h
  );
    if (h == H12_MAX)
      return {pm, HR_W'(1)};
    else if (h == H12_MAX - 5'd1)
      return {~pm, H12_MAX};
    else
      return {pm, h + 5'd1};
  endfunction
`else
  localparam logic [HR_W-1:0] HR_RST = '0;

  function automatic logic [HR_W:0] hr_step(
    input logic pm, input logic [HR_W-1:0] h
  );
    if (h == HR_MAX)
      return {pm, HR_W'(0)};
    else
      return {pm, h + 5'd1};
  endfunction
`endif

  logic set_rise;
  logic inc_rise;

  bin_clock_btn_sync #(.SYNC_FF(SYNC_FF)) u_set (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (bus.btn_set),
    .rise_o (set_rise)
  );

  bin_clock_btn_sync #(.SYNC_FF(SYNC_FF)) u_inc (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (bus.btn_inc),
    .rise_o (inc_rise)
  );

  mode_t            mode_q, mode_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [HR_W-1:0]  hr_q, hr_d;
  logic             pm_q, pm_d;
  logic             pulse_q, pulse_d;
  logic             tick;

  assign tick = (mode_q == RUN) && (pre_q == PRE_MAX);

  always_comb begin
    mode_d  = mode_q;
    pre_d   = pre_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    pm_d    = pm_q;
    pulse_d = 1'b0;

    if (mode_q == RUN)
      pre_d = tick ? '0 : pre_q + PW'(1);

    if (tick) begin
      pulse_d = 1'b1;
      if (sec_q == SEC_MAX) begin
        sec_d = '0;
        if (min_q == MIN_MAX) begin
          min_d = '0;
          {pm_d, hr_d} = hr_step(pm_q, hr_q);
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    // set has priority; a coincident inc is dropped
    if (set_rise) begin
      unique case (mode_q)
        RUN:     mode_d = SET_HR;
        SET_HR:  mode_d = SET_MIN;
        SET_MIN: mode_d = SET_SEC;
        SET_SEC: begin
          mode_d = RUN;
          pre_d  = '0;
        end
      endcase
    end else if (inc_rise) begin
      unique case (mode_q)
        RUN:     ;
        SET_HR:  {pm_d, hr_d} = hr_step(pm_q, hr_q);
        SET_MIN: min_d = (min_q == MIN_MAX) ? '0 : min_q + 6'd1;
        SET_SEC: sec_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= RUN;
      pre_q   <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hr_q    <= HR_RST;
      pm_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      pre_q   <= pre_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      pm_q    <= pm_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.sec       = sec_q;
  assign bus.min       = min_q;
  assign bus.hr        = hr_q;
  assign bus.pm        = pm_q;
  assign bus.mode      = mode_q;
  assign bus.sec_pulse = pulse_q;

endmodule
